// File: rtl/instr_sequencer.sv
// instr_sequencer: eight-phase instruction sequencer for the 8-bit accumulator core; optional retired-instruction counter under INSTR_CNT_EN
module instr_sequencer #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic [2:0]       opcode,
   input  logic             zero,
   output logic             inc_pc,
   output logic             load_pc,
   output logic             load_ir,
   output logic             load_acc,
   output logic             rd,
   output logic             wr,
   output logic             datactl_ena,
   output logic             halt,
   output logic [2:0]       state,
   output logic [CNT_W-1:0] instr_cnt
);
   localparam logic [2:0] HLT = 3'b000, SKZ = 3'b001, ADD = 3'b010, ANDD = 3'b011;
   localparam logic [2:0] XORR = 3'b100, LDA = 3'b101, STO = 3'b110, JMP = 3'b111;
   logic [2:0] r_state, w_state_nxt;
   logic       r_halted, w_halted_nxt;
   logic       w_run, w_alu, w_sto, w_jmp, w_skz_z, w_hlt_now;
   assign w_run     = !reset && enable && !r_halted;
   assign w_alu     = opcode inside {ADD, ANDD, XORR, LDA};
   assign w_sto     = opcode == STO;
   assign w_jmp     = opcode == JMP;
   assign w_skz_z   = opcode == SKZ && zero;
   assign w_hlt_now = w_run && r_state == 3'd3 && opcode == HLT;
   // phase and halt registers
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= '0;
         r_halted <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_halted <= w_halted_nxt;
      end
   end
   // halted freezes, disable parks at S0, HLT holds S3, otherwise advance with wrap
   always_comb begin
      w_state_nxt  = r_halted ? r_state : !enable ? 3'd0 : w_hlt_now ? r_state : r_state + 3'd1;
      w_halted_nxt = r_halted | w_hlt_now;
   end
   // datapath strobes decoded from phase and opcode, all gated by run
   always_comb begin
      load_ir     = w_run && (r_state == 3'd0 || r_state == 3'd1);
      rd          = w_run && (r_state == 3'd0 || r_state == 3'd1 ||
                              (w_alu && (r_state == 3'd4 || r_state == 3'd5 || r_state == 3'd6)));
      inc_pc      = w_run && (r_state == 3'd1 || (r_state == 3'd3 && opcode != HLT) ||
                              (r_state == 3'd5 && (w_skz_z || w_jmp)) || (r_state == 3'd7 && w_skz_z));
      load_pc     = w_run && w_jmp && (r_state == 3'd4 || r_state == 3'd5);
      load_acc    = w_run && w_alu && r_state == 3'd5;
      wr          = w_run && w_sto && r_state == 3'd5;
      datactl_ena = w_run && w_sto && (r_state == 3'd4 || r_state == 3'd5 || r_state == 3'd6);
      halt        = r_halted | w_hlt_now;
      state       = r_state;
   end
`ifdef INSTR_CNT_EN
   logic [CNT_W-1:0] r_instr_cnt;
   // count each retired instruction on the S7->S0 edge, saturating at all-ones
   always_ff @(posedge clk) begin
      if (reset) r_instr_cnt <= '0;
      else if (w_run && r_state == 3'd7 && !(&r_instr_cnt)) r_instr_cnt <= r_instr_cnt + 1'b1;
   end
   assign instr_cnt = r_instr_cnt;
`else
   assign instr_cnt = '0;
`endif
endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: directed self-checking bench for instr_sequencer
module tb_instr_sequencer;
   logic        clk = 1'b0, reset, enable, zero;
   logic [2:0]  opcode, state;
   logic        inc_pc, load_pc, load_ir, load_acc, rd, wr, datactl_ena, halt;
   logic [15:0] instr_cnt;
   int tests = 0, fails = 0;
   // strobe vector order: inc_pc, load_pc, load_ir, load_acc, rd, wr, datactl_ena
   localparam logic [6:0] F0 = 7'b0010100, F1 = 7'b1010100, I3 = 7'b1000000, Z = 7'b0;
   localparam logic [55:0] V_LDA  = {F0, F1, Z, I3, 7'b0000100, 7'b0001100, 7'b0000100, Z};
   localparam logic [55:0] V_STO  = {F0, F1, Z, I3, 7'b0000001, 7'b0000011, 7'b0000001, Z};
   localparam logic [55:0] V_SKZ1 = {F0, F1, Z, I3, Z, I3, Z, I3};
   localparam logic [55:0] V_SKZ0 = {F0, F1, Z, I3, Z, Z, Z, Z};
   localparam logic [55:0] V_JMP  = {F0, F1, Z, I3, 7'b0100000, 7'b1100000, Z, Z};
   wire [6:0] strobes = {inc_pc, load_pc, load_ir, load_acc, rd, wr, datactl_ena};

   instr_sequencer #(.CNT_W(16)) dut (
      .clk(clk), .reset(reset), .enable(enable), .opcode(opcode), .zero(zero),
      .inc_pc(inc_pc), .load_pc(load_pc), .load_ir(load_ir), .load_acc(load_acc),
      .rd(rd), .wr(wr), .datactl_ena(datactl_ena), .halt(halt), .state(state),
      .instr_cnt(instr_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_instr(input string tag, input logic [55:0] v);
      #1;
      for (int s = 0; s < 8; s++) begin
         chk($sformatf("%s_state%0d", tag, s), {13'b0, state}, 16'(s));
         chk($sformatf("%s_strb%0d", tag, s), {9'b0, strobes}, {9'b0, v[(7-s)*7 +: 7]});
         chk($sformatf("%s_rdwr%0d", tag, s), {15'b0, rd & wr}, 16'h0);
         tick();
      end
   endtask

`ifdef INSTR_CNT_EN
   localparam bit CNT = 1'b1;
`else
   localparam bit CNT = 1'b0;
`endif

   function automatic logic [15:0] cnt_exp(input logic [15:0] n);
      return CNT ? n : 16'h0;
   endfunction

   initial begin
      reset = 1'b1; enable = 1'b0; opcode = 3'b000; zero = 1'b0;
      tick(); tick();
      chk("rst_state", {13'b0, state}, 16'h0);
      chk("rst_halt", {15'b0, halt}, 16'h0);
      chk("rst_strb", {9'b0, strobes}, 16'h0);
      chk("rst_cnt", instr_cnt, 16'h0);
      reset = 1'b0; enable = 1'b1; opcode = 3'b101;
      run_instr("lda", V_LDA);
      chk("lda_cnt", instr_cnt, cnt_exp(16'd1));
      opcode = 3'b110;
      run_instr("sto", V_STO);
      opcode = 3'b001; zero = 1'b1;
      run_instr("skz1", V_SKZ1);
      zero = 1'b0;
      run_instr("skz0", V_SKZ0);
      opcode = 3'b111;
      run_instr("jmp", V_JMP);
      chk("jmp_cnt", instr_cnt, cnt_exp(16'd5));
      // abort an ADD at S5
      opcode = 3'b010;
      repeat (5) tick();
      chk("abort_s5", {13'b0, state}, 16'd5);
      chk("abort_s5_strb", {9'b0, strobes}, 16'h000C);
      enable = 1'b0; #1;
      chk("abort_strb_off", {9'b0, strobes}, 16'h0);
      tick();
      chk("abort_state0", {13'b0, state}, 16'h0);
      chk("abort_cnt", instr_cnt, cnt_exp(16'd5));
      tick();
      chk("parked", {13'b0, state}, 16'h0);
      enable = 1'b1;
      run_instr("add", V_LDA);
      chk("add_cnt", instr_cnt, cnt_exp(16'd6));
      // halt
      opcode = 3'b000;
      repeat (3) tick();
      chk("hlt_s3", {13'b0, state}, 16'd3);
      chk("hlt_comb", {15'b0, halt}, 16'h1);
      chk("hlt_strb", {9'b0, strobes}, 16'h0);
      for (int i = 0; i < 20; i++) begin
         tick();
         chk("hlt_hold_state", {13'b0, state}, 16'd3);
         chk("hlt_hold_halt", {15'b0, halt}, 16'h1);
         chk("hlt_hold_strb", {9'b0, strobes}, 16'h0);
      end
      enable = 1'b0; tick();
      chk("hlt_en0_state", {13'b0, state}, 16'd3);
      chk("hlt_en0_halt", {15'b0, halt}, 16'h1);
      enable = 1'b1; opcode = 3'b101; tick();
      chk("hlt_en1_state", {13'b0, state}, 16'd3);
      chk("hlt_en1_strb", {9'b0, strobes}, 16'h0);
      chk("hlt_cnt", instr_cnt, cnt_exp(16'd6));
      reset = 1'b1; tick(); reset = 1'b0; #1;
      chk("clr_state", {13'b0, state}, 16'h0);
      chk("clr_halt", {15'b0, halt}, 16'h0);
      chk("clr_cnt", instr_cnt, 16'h0);
      run_instr("post", V_LDA);
      chk("post_cnt", instr_cnt, cnt_exp(16'd1));
`ifdef INSTR_CNT_EN
      force dut.r_instr_cnt = 16'hFFFF;
      #1;
      release dut.r_instr_cnt;
      run_instr("sat", V_LDA);
      chk("sat_cnt", instr_cnt, 16'hFFFF);
`endif
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
